// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch/data) arbiter onto a single memory port,
// with alternating priority under contention and a per-transaction watchdog.
`default_nettype none

module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_data,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [31:0] d_wdata,
  input  logic        d_extend,
  input  logic [1:0]  d_width,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_data_out,
  output logic        mem_extend,
  output logic [1:0]  mem_width,
  input  logic        mem_ack,
  input  logic [31:0] mem_data_in,
  output logic [1:0]  owner,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2
  } state_t;

  localparam logic [15:0] C_WLIMIT = 16'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic        r_last_d, w_last_d_next;
  logic [15:0] r_wcnt, w_wcnt_next;
  logic        w_sel_i, w_sel_d, w_ack, w_force;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_last_d <= 1'b0;
      r_wcnt   <= 16'd0;
    end else begin
      r_state  <= w_next;
      r_last_d <= w_last_d_next;
      r_wcnt   <= w_wcnt_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_last_d_next = r_last_d;
    w_wcnt_next   = r_wcnt;
    w_sel_i       = 1'b0;
    w_sel_d       = 1'b0;
    w_ack         = 1'b0;
    w_force       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated by reset_n so nothing is granted or acked while reset is held.
        if (reset_n) begin
          if (d_req && (!i_req || !r_last_d)) w_sel_d = 1'b1;
          else if (i_req)                    w_sel_i = 1'b1;
        end
        if (w_sel_i || w_sel_d) begin
          if (mem_ack) begin
            w_ack = 1'b1;
          end else begin
            w_next      = w_sel_d ? S_GNT_D : S_GNT_I;
            w_wcnt_next = 16'd0;
          end
        end
      end
      S_GNT_I, S_GNT_D: begin
        w_sel_i = (r_state == S_GNT_I) && i_req;
        w_sel_d = (r_state == S_GNT_D) && d_req;
        if (!(w_sel_i || w_sel_d)) begin
          w_next = S_IDLE;
        end else if (mem_ack) begin
          w_ack  = 1'b1;
          w_next = S_IDLE;
        end else if (r_wcnt == C_WLIMIT) begin
          w_force = 1'b1;
          w_next  = S_IDLE;
        end else begin
          w_wcnt_next = r_wcnt + 16'd1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_ack || w_force) w_last_d_next = w_sel_d;
  end

  always_comb begin
    mem_req      = w_sel_i | w_sel_d;
    mem_addr     = 32'd0;
    mem_write    = 1'b0;
    mem_data_out = 32'd0;
    mem_extend   = 1'b0;
    mem_width    = 2'b00;
    if (w_sel_d) begin
      mem_addr     = d_addr;
      mem_write    = d_write;
      mem_data_out = d_wdata;
      mem_extend   = d_extend;
      mem_width    = d_width;
    end else if (w_sel_i) begin
      mem_addr  = i_addr;
      mem_width = 2'b10;
    end
  end

  // A forced completion returns zero data rather than whatever is on the bus.
  assign i_ack       = w_sel_i & (w_ack | w_force);
  assign d_ack       = w_sel_d & (w_ack | w_force);
  assign i_data      = (w_sel_i && w_ack) ? mem_data_in : 32'd0;
  assign d_rdata     = (w_sel_d && w_ack) ? mem_data_in : 32'd0;
  assign timeout_err = w_force;
  assign owner       = {w_sel_d | (r_state == S_GNT_D), w_sel_i | (r_state == S_GNT_I)};

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level reference model of the arbiter.
`default_nettype none

module tb_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 0, d_req = 0, d_write = 0, d_extend = 0, mem_ack = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_data_in = 0;
  logic [1:0]  d_width = 0;
  logic        i_ack, d_ack, mem_req, mem_write, mem_extend, timeout_err;
  logic [31:0] i_data, d_rdata, mem_addr, mem_data_out;
  logic [1:0]  mem_width, owner;

  int total = 0;
  int bad = 0;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata),
    .d_extend(d_extend), .d_width(d_width), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_data_out(mem_data_out), .mem_extend(mem_extend), .mem_width(mem_width),
    .mem_ack(mem_ack), .mem_data_in(mem_data_in),
    .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 0; d_req = 0; d_write = 0; d_extend = 0; mem_ack = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_data_in = 0; d_width = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({mem_req, owner, i_ack, d_ack, timeout_err, mem_addr} !== 38'd0) begin
      bad++;
      $display("FAIL reset: got req=%b owner=%b iack=%b dack=%b terr=%b addr=%h, want all 0",
               mem_req, owner, i_ack, d_ack, timeout_err, mem_addr);
    end
    next_cycle();
  endtask

  task automatic test_zero_wait();
    d_req = 1; d_addr = 32'h100; d_write = 1; d_wdata = 32'hCAFEF00D; mem_ack = 1;
    @(negedge clk);
    total++;
    if ({mem_req, mem_addr, mem_data_out, mem_write, d_ack, i_ack, owner} !==
        {1'b1, 32'h100, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 2'b10}) begin
      bad++;
      $display("FAIL zero_wait: got req=%b addr=%h wd=%h we=%b dack=%b iack=%b owner=%b, want 1 100 cafef00d 1 1 0 10",
               mem_req, mem_addr, mem_data_out, mem_write, d_ack, i_ack, owner);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_contention();
    logic [1:0] exp_own;
    do_reset();
    i_req = 1; i_addr = 32'h40; d_req = 1; d_addr = 32'h80;
    for (int k = 0; k < 4; k++) begin
      exp_own = (k % 2 == 0) ? 2'b10 : 2'b01;
      mem_ack = 0;
      @(negedge clk);
      total++;
      if (owner !== exp_own || i_ack !== 1'b0 || d_ack !== 1'b0) begin
        bad++;
        $display("FAIL contention_grant%0d: got owner=%b iack=%b dack=%b, want owner=%b no ack",
                 k, owner, i_ack, d_ack, exp_own);
      end
      next_cycle();
      mem_ack = 1;
      mem_data_in = (k % 2 == 1) ? 32'h13 : 32'h77;
      @(negedge clk);
      total++;
      if (k % 2 == 1) begin
        if ({owner, i_ack, i_data, d_ack, d_rdata} !== {2'b01, 1'b1, 32'h13, 1'b0, 32'h0}) begin
          bad++;
          $display("FAIL contention_fetch%0d: got owner=%b iack=%b idata=%h dack=%b drdata=%h, want 01 1 13 0 0",
                   k, owner, i_ack, i_data, d_ack, d_rdata);
        end
      end else begin
        if ({owner, d_ack, d_rdata, i_ack, i_data} !== {2'b10, 1'b1, 32'h77, 1'b0, 32'h0}) begin
          bad++;
          $display("FAIL contention_data%0d: got owner=%b dack=%b drdata=%h iack=%b idata=%h, want 10 1 77 0 0",
                   k, owner, d_ack, d_rdata, i_ack, i_data);
        end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_grant_lock();
    i_req = 1; i_addr = 32'h40;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin d_req = 1; d_addr = 32'h200; end
      mem_ack = (c == 3);
      @(negedge clk);
      total++;
      if (mem_addr !== 32'h40 || owner !== 2'b01 || i_ack !== (c == 3)) begin
        bad++;
        $display("FAIL grant_lock%0d: got addr=%h owner=%b iack=%b, want 40 01 %0d",
                 c, mem_addr, owner, i_ack, (c == 3));
      end
      next_cycle();
    end
    i_req = 0; mem_ack = 1;
    @(negedge clk);
    total++;
    if (mem_addr !== 32'h200 || owner !== 2'b10 || d_ack !== 1'b1) begin
      bad++;
      $display("FAIL grant_lock_next: got addr=%h owner=%b dack=%b, want 200 10 1",
               mem_addr, owner, d_ack);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_watchdog();
    d_req = 1; d_addr = 32'h300; d_write = 0; mem_data_in = 32'hDEADBEEF;
    for (int c = 0; c <= TO; c++) begin
      @(negedge clk);
      total++;
      if (c < TO) begin
        if (d_ack !== 1'b0 || timeout_err !== 1'b0 || owner !== 2'b10) begin
          bad++;
          $display("FAIL watchdog_wait%0d: got dack=%b terr=%b owner=%b, want 0 0 10",
                   c, d_ack, timeout_err, owner);
        end
      end else begin
        if ({d_ack, d_rdata, timeout_err, i_ack} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
          bad++;
          $display("FAIL watchdog_fire: got dack=%b drdata=%h terr=%b iack=%b, want 1 0 1 0",
                   d_ack, d_rdata, timeout_err, i_ack);
        end
      end
      next_cycle();
    end
    d_req = 0;
    @(negedge clk);
    total++;
    if (owner !== 2'b00 || mem_req !== 1'b0 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL watchdog_idle: got owner=%b req=%b terr=%b, want 00 0 0", owner, mem_req, timeout_err);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_flush();
    d_req = 1; d_addr = 32'h500;
    next_cycle();
    next_cycle();
    d_req = 0; mem_ack = 1;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || d_ack !== 1'b0 || i_ack !== 1'b0) begin
      bad++;
      $display("FAIL flush: got req=%b dack=%b iack=%b, want 0 0 0", mem_req, d_ack, i_ack);
    end
    next_cycle();
    mem_ack = 0;
    @(negedge clk);
    total++;
    if (owner !== 2'b00 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle: got owner=%b req=%b, want 00 0", owner, mem_req);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_midop_reset();
    d_req = 1; d_addr = 32'h600;
    next_cycle();
    @(negedge clk);
    total++;
    if (owner !== 2'b10) begin
      bad++;
      $display("FAIL midreset_pre: got owner=%b, want 10", owner);
    end
    reset_n = 0; d_req = 0;
    #1;
    total++;
    if (owner !== 2'b00 || d_ack !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL midreset_now: got owner=%b dack=%b req=%b, want 00 0 0", owner, d_ack, mem_req);
    end
    next_cycle();
    reset_n = 1; mem_ack = 1;
    @(negedge clk);
    total++;
    if (d_ack !== 1'b0 || i_ack !== 1'b0 || owner !== 2'b00) begin
      bad++;
      $display("FAIL midreset_after: got dack=%b iack=%b owner=%b, want 0 0 00", d_ack, i_ack, owner);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_random();
    int m_own, m_age, g;
    bit m_last_d, done, forced, i_pend, d_pend;
    logic [137:0] exp_v, got_v;
    logic [31:0]  e_addr, e_wd;
    logic         e_we, e_ext;
    logic [1:0]   e_w, e_own;
    do_reset();
    m_own = 0; m_age = 0; m_last_d = 0; i_pend = 0; d_pend = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!i_pend) begin
        if ($urandom_range(1, 0) == 1) begin i_pend = 1; i_addr = $urandom; end
      end else if ($urandom_range(29, 0) == 0) i_pend = 0;
      if (!d_pend) begin
        if ($urandom_range(1, 0) == 1) begin
          d_pend = 1; d_addr = $urandom; d_wdata = $urandom;
          d_write = 1'($urandom); d_extend = 1'($urandom); d_width = 2'($urandom);
        end
      end else if ($urandom_range(29, 0) == 0) d_pend = 0;
      i_req = i_pend; d_req = d_pend;
      mem_ack = ($urandom_range(3, 0) == 0);
      mem_data_in = $urandom;

      if (m_own == 0) g = (d_req && (!i_req || !m_last_d)) ? 2 : (i_req ? 1 : 0);
      else            g = ((m_own == 1 && i_req) || (m_own == 2 && d_req)) ? m_own : 0;
      done = 0; forced = 0;
      if (g != 0) begin
        if (mem_ack) done = 1;
        else if (m_own != 0 && m_age == TO - 1) begin done = 1; forced = 1; end
      end
      e_addr = (g == 2) ? d_addr : (g == 1) ? i_addr : 32'd0;
      e_wd   = (g == 2) ? d_wdata : 32'd0;
      e_we   = (g == 2) ? d_write : 1'b0;
      e_ext  = (g == 2) ? d_extend : 1'b0;
      e_w    = (g == 2) ? d_width : (g == 1) ? 2'b10 : 2'b00;
      e_own  = 2'(m_own != 0 ? m_own : g);
      exp_v = {g != 0, e_addr, e_we, e_wd, e_ext, e_w,
               done && g == 1, (done && !forced && g == 1) ? mem_data_in : 32'd0,
               done && g == 2, (done && !forced && g == 2) ? mem_data_in : 32'd0,
               e_own, forced};

      @(negedge clk);
      got_v = {mem_req, mem_addr, mem_write, mem_data_out, mem_extend, mem_width,
               i_ack, i_data, d_ack, d_rdata, owner, timeout_err};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL random cyc%0d: got %h want %h", cyc, got_v, exp_v);
      end

      if (done) begin
        m_own = 0; m_last_d = (g == 2);
        if (g == 1) i_pend = 0; else d_pend = 0;
      end else if (g != 0 && m_own == 0) begin
        m_own = g; m_age = 0;
      end else if (g != 0) begin
        m_age++;
      end else begin
        m_own = 0;
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_contention();
    test_grant_lock();
    test_watchdog();
    test_flush();
    test_midop_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single memory port between the instruction-fetch stage and the memory stage. It forwards one request at a time onto the memory interface and holds the grant until the transaction completes. It routes the ack and read data back to the requester that owns the grant. A per-transaction watchdog converts a hung memory access into a completed, flagged transaction, so the pipeline never deadlocks.

## Interface
- TIMEOUT, default 255: cycles a granted transaction may wait for `mem_ack` before it is force-completed; legal range 1..65535.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held high until `i_ack`.
- i_addr  in  32  fetch address.
- i_ack  out  1  fetch transaction complete.
- i_data  out  32  fetch read data; valid while `i_ack`.
- d_req  in  1  data request; held high until `d_ack`.
- d_addr  in  32  data address.
- d_write  in  1  1 = store, 0 = load.
- d_wdata  in  32  store data.
- d_extend  in  1  sign-extend loaded value.
- d_width  in  2  access width, passed through unchanged.
- d_ack  out  1  data transaction complete.
- d_rdata  out  32  load data; valid while `d_ack`.
- mem_req, mem_addr[31:0], mem_write, mem_data_out[31:0], mem_extend, mem_width[1:0]  out  downstream request bundle.
- mem_ack  in  1  downstream completion.
- mem_data_in  in  32  downstream read data.
- owner  out  2  current grant: 00 none, 01 fetch, 10 data.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.

## Operation
- State machine has three states: IDLE, GNT_I and GNT_D.
- **Arbitration in IDLE (combinational):**
  - Only `d_req` high: data wins.
  - Only `i_req` high: fetch wins.
  - Both high: data wins unless `last_d`=1, then fetch wins.
  - The winner's bundle drives `mem_*` in the same cycle.
- **Fetch drive values:** `mem_write`=0, `mem_extend`=0, `mem_width`=2'b10, `mem_data_out`=0.
- **Bundle when no request is granted:** `mem_req`=0; all other `mem_*` outputs are 0.
- **`last_d` update:** set to 1 on completion of a data transaction, cleared to 0 on completion of a fetch transaction.
- **Completion:** occurs in any cycle where `mem_req` & `mem_ack` are both high.
  - `mem_ack` is forwarded combinationally to the owner's ack.
  - `mem_data_in` is forwarded to the owner's data output.
  - The non-owner's ack stays 0.
  - Next state is IDLE.
- **Wait for ack:**
  - If the winner is not acked in its first cycle, state goes to GNT_I or GNT_D.
  - The grant is locked: a higher-priority request arriving later does not preempt it.
- **Requester withdrawal (flush):**
  - In GNT_x, if the owner's req is low, `mem_req` is 0 that cycle.
  - Any `mem_ack` in that cycle is ignored, with no ack to either side.
  - Next state is IDLE; `last_d` is unchanged.
- **Watchdog:**
  - `wcnt` (16 bits) clears on entry to GNT_x and increments each cycle in GNT_x without ack.
  - When `wcnt` reaches TIMEOUT-1 with no ack: the owner's ack is forced to 1 with data 32'h0000_0000, `timeout_err` is 1 that cycle, and the transaction counts as a completion (`last_d` updates).
- `owner` reflects the grant in the current cycle, including the combinational winner in IDLE.

## Timing
- **Reset values:** state=IDLE, `last_d`=0, `wcnt`=0, `timeout_err`=0. With both reqs low, every output is 0.
- **Reset mid-transaction:** state returns to IDLE immediately and asynchronously; the in-flight access is abandoned and no ack is produced.
- **Best-case latency:** 0 cycles. Request and ack may occur in the same cycle, and back-to-back transactions can complete on consecutive cycles.
- **Handshake contract:** a requester holds its bundle stable while req is high and not acked. The arbiter holds `mem_*` stable while it is in GNT_x.
- **Simultaneous events:**
  - Ack and watchdog expiry in the same cycle: treated as a normal ack, with `timeout_err`=0.
  - Owner withdraws req in the same cycle as ack: the withdrawal wins.
- **Fairness:** under continuous requests from both sides, grants alternate D, I, D, I…; no requester waits more than one other transaction.

## Test plan
- **Reset:** after reset_n deassertion with no requests -> `mem_req`=0, `owner`=00, all acks 0.
- **Single request, zero-wait:** `d_req`, `d_addr`=32'h100, `d_write`=1, `d_wdata`=32'hCAFEF00D, with `mem_ack` in the same cycle -> `mem_addr`=32'h100, `mem_data_out`=32'hCAFEF00D, `d_ack`=1 that cycle, `i_ack`=0.
- **Contention and fairness:** `i_req` and `d_req` held high continuously, each mem access acked after 2 cycles -> owner sequence 10,01,10,01; a fetch read of `mem_data_in`=32'h13 appears only on `i_data`.
- **Grant lock:** fetch granted at 32'h40 and waiting; `d_req` rises while fetch is waiting -> `mem_addr` stays 32'h40 until ack, then data is granted in the next cycle.
- **Watchdog:** TIMEOUT=4, data load with `mem_ack` never asserted -> `d_ack`=1, `d_rdata`=0 and `timeout_err`=1 on the 4th granted cycle; next cycle is IDLE.
- **Flush and mid-op reset:**
  - Owner drops req while waiting -> `mem_req`=0 and no ack.
  - reset_n pulsed low while in GNT_D -> `owner`=00 immediately, with no ack afterwards.
